// File: rtl/ram_stream_reader.sv
// Streams len consecutive words from a combinational-read memory, starting at
// base and wrapping modulo depth_p, over a registered valid/ready output.
module ram_stream_reader #(
  parameter int width_p = 8,
  parameter int depth_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         start_i,
  output logic                         start_ready_o,
  input  logic [$clog2(depth_p)-1:0]   base_addr_i,
  input  logic [$clog2(depth_p+1)-1:0] len_i,
  output logic [$clog2(depth_p)-1:0]   rd_addr_o,
  input  logic [width_p-1:0]           rd_data_i,
  output logic [width_p-1:0]           data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         last_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [1:0]                   state_o
);

  localparam int aw = $clog2(depth_p);
  localparam int lw = $clog2(depth_p + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Handshakes: a start transfers on a clock edge where start_i & start_ready_o;
  // an output word transfers on an edge where valid_o & ready_i. Once valid_o
  // is high, data_o/last_o/valid_o stay put until that transfer happens.
  state_t              state_q, state_d;
  logic [aw-1:0]       addr_q, addr_d;
  logic [lw-1:0]       rem_q, rem_d;
  logic [width_p-1:0]  data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                out_free;

  assign out_free = ~valid_q | ready_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          rem_d   = len_i;
          state_d = (len_i != '0) ? STREAM : DONE;
        end
      end
      STREAM: begin
        if (out_free) begin
          if (rem_q != '0) begin
            // rd_data_i is already valid for addr_q thanks to the async read.
            data_d  = rd_data_i;
            valid_d = 1'b1;
            last_d  = (rem_q == lw'(1));
            addr_d  = (addr_q == aw'(depth_p - 1)) ? '0 : addr_q + aw'(1);
            rem_d   = rem_q - lw'(1);
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign start_ready_o = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign rd_addr_o     = addr_q;
  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign last_o        = last_q;
  assign state_o       = state_q;

endmodule
